// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: op/funct decode plus a Moore FSM that sequences the
// multicycle datapath selects, enables, ALU operation and memory write strobe.
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       IorD,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  // state  | meaning
  // FETCH  | read instruction at pc, pc <= pc+4, load IR
  // DECODE | read registers, precompute branch target into aluout
  // MEMADR | compute lw/sw effective address
  // MEMRD  | read data memory at aluout
  // MEMWB  | write loaded data to rt
  // MEMWR  | write B to memory at aluout
  // EXEC   | R-type ALU operation
  // ALUWB  | write R-type result to rd
  // BRANCH | compare A,B; take branch when zero
  // ADDIEX | A + signimm
  // ADDIWB | write addi result to rt
  // JUMP   | pc <= jump target
  // HALT   | parked after an illegal instruction (trap build only)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic logic instr_legal(input logic [5:0] o, input logic [5:0] fn);
    case (o)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      OP_RTYPE: return funct_legal(fn);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t st, input logic [5:0] o,
                                        input logic [5:0] fn);
    state_t ns;
    ns = S_FETCH;
    case (st)
      S_FETCH: ns = S_DECODE;
      S_DECODE: begin
        if (!instr_legal(o, fn)) ns = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        else begin
          case (o)
            OP_LW, OP_SW: ns = S_MEMADR;
            OP_RTYPE:     ns = S_EXEC;
            OP_BEQ:       ns = S_BRANCH;
            OP_ADDI:      ns = S_ADDIEX;
            OP_J:         ns = S_JUMP;
            default:      ns = S_FETCH;
          endcase
        end
      end
      S_MEMADR: ns = (o == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  ns = S_MEMWB;
      S_EXEC:   ns = S_ALUWB;
      S_ADDIEX: ns = S_ADDIWB;
      S_HALT:   ns = S_HALT;
      default:  ns = S_FETCH;
    endcase
    return ns;
  endfunction

  // funct only matters in EXEC; the IR is stable for the whole instruction
  function automatic ctrl_t ctrl_for(input state_t st, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.alusrcb    = 2'b01;
        c.alucontrol = ALU_ADD;
        c.irwrite    = 1'b1;
        c.pcwrite    = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb    = 2'b11;
        c.alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b10;
        c.alucontrol = ALU_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca    = 1'b1;
        c.alucontrol = funct_alu(fn);
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alucontrol = ALU_SUB;
        c.pcsrc      = 2'b01;
        c.branch     = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctrl_t  r_ctrl;
  logic   r_illegal;
  state_t w_next;
  logic   w_illegal_dec;

  assign w_next        = next_state(r_state, op, funct);
  assign w_illegal_dec = (r_state == S_DECODE) && !instr_legal(op, funct);

  // Outputs are registered alongside the state so they are always the decode of r_state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= ctrl_for(S_FETCH, 6'd0);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next, funct);
      if (w_illegal_dec) r_illegal <= 1'b1;
    end
  end

  assign pcen       = ~reset & (r_ctrl.pcwrite | (r_ctrl.branch & zero));
  assign irwrite    = ~reset & r_ctrl.irwrite;
  assign memwrite   = ~reset & r_ctrl.memwrite;
  assign regwrite   = ~reset & r_ctrl.regwrite;
  assign IorD       = r_ctrl.iord;
  assign memtoreg   = r_ctrl.memtoreg;
  assign regdst     = r_ctrl.regdst;
  assign alusrca    = r_ctrl.alusrca;
  assign alusrcb    = r_ctrl.alusrcb;
  assign pcsrc      = r_ctrl.pcsrc;
  assign alucontrol = r_ctrl.alucontrol;
  assign illegal    = r_illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random instruction streams compared
// against a per-instruction state-sequence and per-state output table model.
module tb_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rst2, zero;
  logic [5:0] op, funct, op2, funct2;

  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       pcen_t, irwrite_t, memwrite_t, regwrite_t, iord_t, memtoreg_t, regdst_t;
  logic       alusrca_t, illegal_t;
  logic [1:0] alusrcb_t, pcsrc_t;
  logic [2:0] alucontrol_t;
  logic [3:0] state_t_o;

  mc_controller #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .IorD(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  mc_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(rst2), .op(op2), .funct(funct2), .zero(zero),
    .pcen(pcen_t), .irwrite(irwrite_t), .memwrite(memwrite_t), .regwrite(regwrite_t),
    .IorD(iord_t), .memtoreg(memtoreg_t), .regdst(regdst_t), .alusrca(alusrca_t),
    .alusrcb(alusrcb_t), .pcsrc(pcsrc_t), .alucontrol(alucontrol_t),
    .illegal(illegal_t), .state(state_t_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_illegal = 1'b0;

  logic [5:0] funct_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [2:0] alu_tab   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  int exp_len;
  int exp_s [5];
  bit exp_ill;
  int exp_writes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (funct_tab[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (funct_tab[i] == fn) return alu_tab[i];
    return 3'bxxx;
  endfunction

  // {irwrite,memwrite,regwrite,IorD,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [13:0] exp_ctrl(input int st, input logic [5:0] fn);
    logic ir, mw, rw, io, mt, rd, sa;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {ir, mw, rw, io, mt, rd, sa, sb, ps, ac} = '0;
    case (st)
      0:  begin ir = 1; sb = 2'b01; ac = 3'b010; end
      1:  begin sb = 2'b11; ac = 3'b010; end
      2:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3:  io = 1;
      4:  begin mt = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ac = alu_of(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      10: rw = 1;
      11: ps = 2'b10;
      default: ;
    endcase
    return {ir, mw, rw, io, mt, rd, sa, sb, ps, ac};
  endfunction

  function automatic logic exp_pcen(input int st, input logic z);
    return (st == 0) || (st == 11) || (st == 8 && z);
  endfunction

  task automatic set_seq(input int n, input int a0, a1, a2, a3, a4, input bit ill, input int w);
    exp_len = n;
    exp_s[0] = a0; exp_s[1] = a1; exp_s[2] = a2; exp_s[3] = a3; exp_s[4] = a4;
    exp_ill = ill;
    exp_writes = w;
  endtask

  task automatic build_seq(input logic [5:0] o, input logic [5:0] fn);
    case (o)
      6'h23: set_seq(5, 0, 1, 2, 3, 4, 0, 1);
      6'h2b: set_seq(4, 0, 1, 2, 5, 0, 0, 1);
      6'h00: if (funct_ok(fn)) set_seq(4, 0, 1, 6, 7, 0, 0, 1);
             else              set_seq(2, 0, 1, 0, 0, 0, 1, 0);
      6'h04: set_seq(3, 0, 1, 8, 0, 0, 0, 0);
      6'h08: set_seq(4, 0, 1, 9, 10, 0, 0, 1);
      6'h02: set_seq(3, 0, 1, 11, 0, 0, 0, 0);
      default: set_seq(2, 0, 1, 0, 0, 0, 1, 0);
    endcase
  endtask

  function automatic logic [13:0] dut_ctrl();
    return {irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol};
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 back in FETCH
  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn);
    int wr, irc, st;
    wr = 0;
    irc = 0;
    build_seq(o, fn);
    for (int k = 0; k < exp_len; k++) begin
      if (k == 0) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        op    = o;
        funct = fn;
      end
      zero = 1'($urandom_range(0, 1));
      #1;
      st = exp_s[k];
      chk("state", 32'(state), 32'(st));
      chk("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(st, fn)));
      chk("pcen", 32'(pcen), 32'(exp_pcen(st, zero)));
      chk("illegal", 32'(illegal), 32'(exp_illegal));
      wr  += int'(regwrite) + int'(memwrite);
      irc += int'(irwrite);
      @(posedge clk); #1;
      if (k == 1 && exp_ill) exp_illegal = 1'b1;
    end
    chk("write_pulses", 32'(wr), 32'(exp_writes));
    chk("irwrite_pulses", 32'(irc), 32'd1);
  endtask

  initial begin
    logic [5:0] ro, rf;
    int sel;
    reset = 1'b1; rst2 = 1'b1; zero = 1'b0;
    op = 6'h00; funct = 6'h20; op2 = 6'h00; funct2 = 6'h20;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    // trap build: illegal op parks in HALT until reset
    rst2 = 1'b0;
    #1;
    chk("trap_fetch_state", 32'(state_t_o), 32'd0);
    chk("trap_fetch_strobes", 32'({pcen_t, irwrite_t}), 32'b11);
    op2 = 6'h3f; funct2 = 6'($urandom);
    @(posedge clk); #1;
    chk("trap_decode", 32'(state_t_o), 32'd1);
    @(posedge clk); #1;
    chk("trap_halt", 32'(state_t_o), 32'd12);
    chk("trap_illegal", 32'(illegal_t), 32'd1);
    for (int i = 0; i < 22; i++) begin
      op2 = 6'($urandom); funct2 = 6'($urandom); zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("trap_hold_state", 32'(state_t_o), 32'd12);
      chk("trap_hold_out", 32'({pcen_t, irwrite_t, memwrite_t, regwrite_t, iord_t, memtoreg_t,
                               regdst_t, alusrca_t, alusrcb_t, pcsrc_t, alucontrol_t}), 32'd0);
    end
    rst2 = 1'b1;
    #1;
    chk("trap_rst_state", 32'(state_t_o), 32'd0);
    chk("trap_rst_illegal", 32'(illegal_t), 32'd0);

    // main build: directed then random instructions
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(6'h23, 6'h11);
    run_instr(6'h2b, 6'h07);
    for (int i = 0; i < 5; i++) run_instr(6'h00, funct_tab[i]);
    run_instr(6'h04, 6'h00);
    run_instr(6'h08, 6'h3c);
    run_instr(6'h02, 6'h15);
    run_instr(6'h3f, 6'h20);
    run_instr(6'h00, 6'h00);
    run_instr(6'h23, 6'h20);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 11);
      rf  = 6'($urandom);
      case (sel)
        0: ro = 6'h23;
        1: ro = 6'h2b;
        2, 3, 4, 5, 6: begin ro = 6'h00; rf = funct_tab[sel - 2]; end
        7: ro = 6'h04;
        8: ro = 6'h08;
        9: ro = 6'h02;
        10: begin
          ro = 6'($urandom);
          if (ro inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02}) ro = 6'h3f;
        end
        default: begin
          ro = 6'h00;
          if (funct_ok(rf)) rf = 6'h01;
        end
      endcase
      run_instr(ro, rf);
    end

    // reset in the middle of a load abandons it
    op = 6'h23; funct = 6'h20; zero = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_memrd", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    exp_illegal = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    chk("held_rst_state", 32'(state), 32'd0);
    chk("held_rst_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, 6'h00)));
    chk("post_rst_pcen", 32'(pcen), 32'd1);
    run_instr(6'h23, 6'h00);
    run_instr(6'h04, 6'h00);
    run_instr(6'h00, 6'h2a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
